// File: rtl/approx_mon_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
// Holds the controller states, default widths and the saturating add.
package approx_mon_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } mon_state_e;

  // Operands are zero-extended to 64 bits; the result clips at lim (the all-ones value of the target).
  function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                          input logic [63:0] lim);
    logic [64:0] sum;
    logic [63:0] res;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum >= {1'b0, lim}) begin
      res = lim;
    end else begin
      res = sum[63:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Two-stage error calculator: exact sum, then absolute difference to the approximate sum.
// Width-generic so it can serve other adder sizes.
module approx_err_calc
  import approx_mon_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W:0]   in_approx,
  output logic         s1_valid,
  output logic         s2_valid,
  output logic [W-1:0] s2_a,
  output logic [W-1:0] s2_b,
  output logic [W:0]   s2_diff,
  output logic         s2_ne
);

  logic         s1_valid_r;
  logic [W-1:0] s1_a_r;
  logic [W-1:0] s1_b_r;
  logic [W:0]   s1_approx_r;
  logic [W:0]   s1_exact_r;
  logic         s2_valid_r;
  logic [W-1:0] s2_a_r;
  logic [W-1:0] s2_b_r;
  logic [W:0]   s2_diff_r;
  logic         s2_ne_r;
  logic [W:0]   diff_s;

  // Absolute difference: compare unsigned first so the subtraction never wraps.
  always_comb begin
    diff_s = '0;
    if (s1_exact_r >= s1_approx_r) begin
      diff_s = s1_exact_r - s1_approx_r;
    end else begin
      diff_s = s1_approx_r - s1_exact_r;
    end
  end

  // Stage 1 and stage 2 registers; the pipeline never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_approx_r <= '0;
      s1_exact_r  <= '0;
      s2_valid_r  <= 1'b0;
      s2_a_r      <= '0;
      s2_b_r      <= '0;
      s2_diff_r   <= '0;
      s2_ne_r     <= 1'b0;
    end else begin
      s1_valid_r  <= in_valid;
      s1_a_r      <= in_a;
      s1_b_r      <= in_b;
      s1_approx_r <= in_approx;
      s1_exact_r  <= {1'b0, in_a} + {1'b0, in_b};
      s2_valid_r  <= s1_valid_r;
      s2_a_r      <= s1_a_r;
      s2_b_r      <= s1_b_r;
      s2_diff_r   <= diff_s;
      s2_ne_r     <= (diff_s != '0);
    end
  end

  assign s1_valid = s1_valid_r;
  assign s2_valid = s2_valid_r;
  assign s2_a     = s2_a_r;
  assign s2_b     = s2_b_r;
  assign s2_diff  = s2_diff_r;
  assign s2_ne    = s2_ne_r;

endmodule

// File: rtl/approx_add_err_monitor.sv
// Error-statistics monitor for approximate adders: accumulates count, error count,
// absolute-error sum and worst case, handing them out via a snapshot handshake.
module approx_add_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  input  logic             clear,
  input  logic             snap_req,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] err_sum,
  output logic [WIDTH:0]   err_max,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] max_b,
  output logic             sat
);

  mon_state_e       state_r, state_nxt_s;
  logic             accept_s;
  logic             s1_valid_s, s2_valid_s, s2_ne_s;
  logic [WIDTH-1:0] s2_a_s, s2_b_s;
  logic [WIDTH:0]   s2_diff_s;
  logic             s3_valid_r, s3_ne_r;
  logic [WIDTH-1:0] s3_a_r, s3_b_r;
  logic [WIDTH:0]   s3_diff_r;
  logic [CNT_W-1:0] samples_r, err_count_r, samples_nxt_s, err_count_nxt_s;
  logic [ACC_W-1:0] err_sum_r, err_sum_nxt_s;
  logic [WIDTH:0]   err_max_r;
  logic [WIDTH-1:0] max_a_r, max_b_r;
  logic             sat_r, sat_hit_s, clear_ok_s;

  assign in_ready   = (state_r == RUN) && !rst;
  assign accept_s   = in_valid && in_ready;
  assign stat_valid = (state_r == REPORT);
  assign clear_ok_s = clear && (state_r != REPORT);

  approx_err_calc #(.W(WIDTH)) u_calc (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept_s),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_approx(in_approx),
    .s1_valid (s1_valid_s),
    .s2_valid (s2_valid_s),
    .s2_a     (s2_a_s),
    .s2_b     (s2_b_s),
    .s2_diff  (s2_diff_s),
    .s2_ne    (s2_ne_s)
  );

  // Controller next state: a snapshot drains the pipe, then holds until consumed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (snap_req) state_nxt_s = DRAIN;
        else          state_nxt_s = RUN;
      end
      DRAIN: begin
        if (!s1_valid_s && !s2_valid_s && !s3_valid_r) state_nxt_s = REPORT;
        else                                            state_nxt_s = DRAIN;
      end
      REPORT: begin
        if (stat_ready) state_nxt_s = RUN;
        else            state_nxt_s = REPORT;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Saturating next values; reaching all-ones on any of them raises the sticky flag.
  always_comb begin
    samples_nxt_s   = CNT_W'(sat_add(64'(samples_r), 64'd1, 64'({CNT_W{1'b1}})));
    err_count_nxt_s = CNT_W'(sat_add(64'(err_count_r), 64'(s3_ne_r), 64'({CNT_W{1'b1}})));
    err_sum_nxt_s   = ACC_W'(sat_add(64'(err_sum_r), 64'(s3_diff_r), 64'({ACC_W{1'b1}})));
    sat_hit_s       = (&samples_nxt_s) || (&err_count_nxt_s) || (&err_sum_nxt_s);
  end

  // State and stage-3 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      s3_valid_r <= 1'b0;
      s3_ne_r    <= 1'b0;
      s3_a_r     <= '0;
      s3_b_r     <= '0;
      s3_diff_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      s3_valid_r <= s2_valid_s;
      s3_ne_r    <= s2_ne_s;
      s3_a_r     <= s2_a_s;
      s3_b_r     <= s2_b_s;
      s3_diff_r  <= s2_diff_s;
    end
  end

  // Statistics: clear beats a simultaneous stage-3 beat; ties on the maximum keep the earlier beat.
  always_ff @(posedge clk) begin
    if (rst || clear_ok_s) begin
      samples_r   <= '0;
      err_count_r <= '0;
      err_sum_r   <= '0;
      err_max_r   <= '0;
      max_a_r     <= '0;
      max_b_r     <= '0;
      sat_r       <= 1'b0;
    end else if (s3_valid_r) begin
      samples_r   <= samples_nxt_s;
      err_count_r <= err_count_nxt_s;
      err_sum_r   <= err_sum_nxt_s;
      sat_r       <= sat_r || sat_hit_s;
      if (s3_diff_r > err_max_r) begin
        err_max_r <= s3_diff_r;
        max_a_r   <= s3_a_r;
        max_b_r   <= s3_b_r;
      end else begin
        err_max_r <= err_max_r;
      end
    end else begin
      sat_r <= sat_r;
    end
  end

  assign samples   = samples_r;
  assign err_count = err_count_r;
  assign err_sum   = err_sum_r;
  assign err_max   = err_max_r;
  assign max_a     = max_a_r;
  assign max_b     = max_b_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Scoreboard bench for approx_add_err_monitor: directed beats, hand-computed snapshots
// queued at request time and compared by a monitor while stat_valid is high.
module tb_approx_add_err_monitor;

  typedef struct {
    logic [31:0] samples;
    logic [31:0] err_count;
    logic [47:0] err_sum;
    logic [16:0] err_max;
    logic [15:0] max_a;
    logic [15:0] max_b;
    logic        sat;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [16:0] in_approx = 17'd0;
  logic        clear = 1'b0;
  logic        snap_req = 1'b0;
  logic        stat_valid;
  logic        stat_ready = 1'b0;
  logic [31:0] samples, err_count;
  logic [47:0] err_sum;
  logic [16:0] err_max;
  logic [15:0] max_a, max_b;
  logic        sat;

  int    n_checks = 0;
  int    n_fail = 0;
  snap_t exp_q[$];

  approx_add_err_monitor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .clear(clear),
    .snap_req(snap_req), .stat_valid(stat_valid), .stat_ready(stat_ready),
    .samples(samples), .err_count(err_count), .err_sum(err_sum), .err_max(err_max),
    .max_a(max_a), .max_b(max_b), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic snap_t mk(input logic [31:0] s, input logic [31:0] e, input logic [47:0] sm,
                               input logic [16:0] mx, input logic [15:0] a, input logic [15:0] b,
                               input logic st);
    snap_t r;
    r.samples = s; r.err_count = e; r.err_sum = sm; r.err_max = mx;
    r.max_a = a; r.max_b = b; r.sat = st;
    return r;
  endfunction

  // Monitor: every cycle the snapshot is presented it must match the queued expectation.
  always @(negedge clk) begin
    if (!rst && stat_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_snapshot", 64'(stat_valid), 64'd0);
      end else begin
        snap_t e;
        e = exp_q[0];
        chk("samples",   64'(samples),   64'(e.samples));
        chk("err_count", 64'(err_count), 64'(e.err_count));
        chk("err_sum",   64'(err_sum),   64'(e.err_sum));
        chk("err_max",   64'(err_max),   64'(e.err_max));
        chk("max_a",     64'(max_a),     64'(e.max_a));
        chk("max_b",     64'(max_b),     64'(e.max_b));
        chk("sat",       64'(sat),       64'(e.sat));
        if (stat_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
    in_valid = 1'b1; in_a = a; in_b = b; in_approx = ap;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic do_snap(input snap_t e, input bit with_beat, input logic [15:0] a,
                         input logic [15:0] b, input logic [16:0] ap, input int hold,
                         input int maxwait);
    int waited;
    bit got;
    exp_q.push_back(e);
    snap_req = 1'b1;
    if (with_beat) begin
      in_valid = 1'b1; in_a = a; in_b = b; in_approx = ap;
    end
    @(posedge clk); #1;
    snap_req = 1'b0;
    in_valid = 1'b0;
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stat_valid) begin
        got = 1'b1;
        waited = i + 1;
        break;
      end
    end
    chk("stat_valid_timeout", 64'(got), 64'd1);
    chk("snap_latency_ok", 64'(waited <= maxwait), 64'd1);
    for (int h = 0; h < hold; h++) begin
      chk("in_ready_in_report", 64'(in_ready), 64'd0);
      chk("stat_valid_held", 64'(stat_valid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    stat_ready = 1'b1;
    @(posedge clk); #1;
    stat_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    chk("stat_valid_after_handshake", 64'(stat_valid), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    chk("stat_valid_in_reset", 64'(stat_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Empty snapshot straight after reset.
    do_snap(mk(32'd0, 32'd0, 48'd0, 17'd0, 16'd0, 16'd0, 1'b0), 1'b0, 16'd0, 16'd0, 17'd0, 0, 4);

    // Diffs 2, 0, 0x10000.
    send(16'd1, 16'd1, 17'd0);
    send(16'd3, 16'd5, 17'd8);
    send(16'hFFFF, 16'd1, 17'h00000);
    do_snap(mk(32'd3, 32'd2, 48'd65538, 17'h10000, 16'hFFFF, 16'd1, 1'b0),
            1'b0, 16'd0, 16'd0, 17'd0, 0, 8);

    // Tie on the maximum keeps the first beat.
    pulse_clear();
    send(16'd2, 16'd2, 17'd0);
    send(16'd4, 16'd0, 17'd0);
    do_snap(mk(32'd2, 32'd2, 48'd8, 17'd4, 16'd2, 16'd2, 1'b0), 1'b0, 16'd0, 16'd0, 17'd0, 0, 8);

    // Beat in the same cycle as snap_req, consumer stalls 5 cycles.
    pulse_clear();
    do_snap(mk(32'd1, 32'd0, 48'd0, 17'd0, 16'd0, 16'd0, 1'b0), 1'b1, 16'd5, 16'd6, 17'd11, 5, 6);

    // Clear while two beats (diffs 3 and 1) sit in S2/S1; the earlier diff-20 beat is wiped.
    pulse_clear();
    send(16'd10, 16'd10, 17'd0);
    idle(5);
    send(16'd1, 16'd2, 17'd0);
    send(16'd7, 16'd1, 17'd7);
    pulse_clear();
    do_snap(mk(32'd2, 32'd2, 48'd4, 17'd3, 16'd1, 16'd2, 1'b0), 1'b0, 16'd0, 16'd0, 17'd0, 0, 8);

    // Sample counter saturation from a preloaded near-full value.
    pulse_clear();
    idle(2);
    dut.samples_r = 32'hFFFF_FFFE;
    send(16'd1, 16'd1, 17'd2);
    send(16'd1, 16'd1, 17'd2);
    send(16'd1, 16'd1, 17'd2);
    do_snap(mk(32'hFFFF_FFFF, 32'd0, 48'd0, 17'd0, 16'd0, 16'd0, 1'b1),
            1'b0, 16'd0, 16'd0, 17'd0, 0, 8);
    pulse_clear();
    do_snap(mk(32'd0, 32'd0, 48'd0, 17'd0, 16'd0, 16'd0, 1'b0), 1'b0, 16'd0, 16'd0, 17'd0, 0, 4);

    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
